// File: rtl/fifo_controller_pkg.sv
// ---------------------------------------------------------------------------
// fifo_controller_pkg
//   Shared definitions for the multiplexed-pointer FIFO sequencer.
//   - state_t      : 3-bit FSM state encoding
//   - GRANT_*      : encoding of the last side granted (round-robin memory)
//   - depth_of()   : usable FIFO entries for a given pointer width
//                    (location 0 is reserved, so one less than 2**(aw+1))
// ---------------------------------------------------------------------------
package fifo_controller_pkg;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_W_ADDR = 3'd2,
    S_W_MEM  = 3'd3,
    S_R_ADDR = 3'd4,
    S_R_MEM  = 3'd5,
    S_R_DONE = 3'd6
  } state_t;

  localparam logic GRANT_READ  = 1'b0;
  localparam logic GRANT_WRITE = 1'b1;

  function automatic int depth_of(input int add_width);
    return (1 << (add_width + 1)) - 1;
  endfunction

endpackage

// File: rtl/fifo_controller_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_rr_arbiter
//   Two-way round-robin arbiter for the shared FIFO address pointer.
//   Purely combinational.
//   Ports:
//     wr_elig    in  writer has a request that may be served (not full)
//     rd_elig    in  reader has a request that may be served (not empty)
//     last_grant in  side served most recently (GRANT_WRITE / GRANT_READ)
//     grant_wr   out grant the writer
//     grant_rd   out grant the reader
//   At most one grant is asserted. When both sides are eligible the side
//   opposite last_grant wins.
// ---------------------------------------------------------------------------
module fifo_rr_arbiter
  import fifo_controller_pkg::*;
(
  input  logic wr_elig,
  input  logic rd_elig,
  input  logic last_grant,
  output logic grant_wr,
  output logic grant_rd
);

  logic contention;

  assign contention = wr_elig & rd_elig;

  assign grant_wr = wr_elig & (~contention | (last_grant == GRANT_READ));
  assign grant_rd = rd_elig & (~contention | (last_grant == GRANT_WRITE));

endmodule

// File: rtl/fifo_controller.sv
// ---------------------------------------------------------------------------
// fifo_controller
//   Sequencer between a writer and a reader requester and the shared
//   pointer/RAM datapath of a multiplexed-pointer FIFO. Serializes accesses
//   onto the single address pointer, keeps its own occupancy count and
//   rejects overflow/underflow requests without touching the datapath.
//
//   Ports:
//     clk          in   system clock, rising edge
//     Clear        in   asynchronous active-high reset
//     wr_req       in   writer request, held until wr_ack or wr_err
//     rd_req       in   reader request, held until rd_ack or rd_err
//     wr_ack       out  pulse: write committed to RAM
//     rd_ack       out  pulse: read data valid on RAM output
//     wr_err       out  pulse: write rejected, FIFO full
//     rd_err       out  pulse: read rejected, FIFO empty
//     sel          out  pointer mux select (1 = write ptr, 0 = read ptr)
//     EnableP      out  pointer enable, one cycle per granted access
//     ram_we       out  RAM write strobe
//     ram_re       out  RAM read strobe
//     ptr_clear_n  out  active-low synchronous clear to the pointer
//     count        out  occupancy 0..DEPTH
//     full         out  count == DEPTH (registered)
//     empty        out  count == 0     (registered)
//
//   Sequences (all outputs are registered, decoded for the state entered):
//     write : IDLE -> W_ADDR -> W_MEM -> IDLE            (3 cycles)
//     read  : IDLE -> R_ADDR -> R_MEM -> R_DONE -> IDLE  (4 cycles)
// ---------------------------------------------------------------------------
module fifo_controller
  import fifo_controller_pkg::*;
#(
  parameter int ADD_WIDTH = 4
) (
  input  logic               clk,
  input  logic               Clear,
  input  logic               wr_req,
  input  logic               rd_req,
  output logic               wr_ack,
  output logic               rd_ack,
  output logic               wr_err,
  output logic               rd_err,
  output logic               sel,
  output logic               EnableP,
  output logic               ram_we,
  output logic               ram_re,
  output logic               ptr_clear_n,
  output logic [ADD_WIDTH:0] count,
  output logic               full,
  output logic               empty
);

  localparam int                 DEPTH     = depth_of(ADD_WIDTH);
  localparam logic [ADD_WIDTH:0] DEPTH_CNT = DEPTH[ADD_WIDTH:0];
  localparam logic [ADD_WIDTH:0] CNT_ONE   = {{ADD_WIDTH{1'b0}}, 1'b1};

  state_t state;
  logic   last_grant;
  logic   wr_elig;
  logic   rd_elig;
  logic   grant_wr;
  logic   grant_rd;

  assign wr_elig = wr_req & ~full;
  assign rd_elig = rd_req & ~empty;

  fifo_rr_arbiter u_arb (
    .wr_elig    (wr_elig),
    .rd_elig    (rd_elig),
    .last_grant (last_grant),
    .grant_wr   (grant_wr),
    .grant_rd   (grant_rd)
  );

  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      state       <= S_INIT;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      last_grant  <= GRANT_READ;
      sel         <= 1'b0;
      EnableP     <= 1'b0;
      ram_we      <= 1'b0;
      ram_re      <= 1'b0;
      wr_ack      <= 1'b0;
      rd_ack      <= 1'b0;
      wr_err      <= 1'b0;
      rd_err      <= 1'b0;
      ptr_clear_n <= 1'b1;
    end else begin
      // Strobes and pulses default low; sel is deliberately not defaulted
      // so the pointer mux holds its last value between accesses.
      EnableP     <= 1'b0;
      ram_we      <= 1'b0;
      ram_re      <= 1'b0;
      wr_ack      <= 1'b0;
      rd_ack      <= 1'b0;
      wr_err      <= 1'b0;
      rd_err      <= 1'b0;
      ptr_clear_n <= 1'b1;

      unique case (state)
        // First INIT cycle launches the pointer clear, second one releases
        // it and moves on, so ptr_clear_n is low for exactly one cycle.
        S_INIT: begin
          if (ptr_clear_n) begin
            ptr_clear_n <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end

        S_IDLE: begin
          // The requester is still holding its request during the cycle the
          // error pulse is visible; masking with the current pulse keeps a
          // single rejection from turning into a two-cycle error.
          wr_err <= wr_req & full  & ~wr_err;
          rd_err <= rd_req & empty & ~rd_err;
          if (grant_wr) begin
            state   <= S_W_ADDR;
            sel     <= 1'b1;
            EnableP <= 1'b1;
          end else if (grant_rd) begin
            state   <= S_R_ADDR;
            sel     <= 1'b0;
            EnableP <= 1'b1;
          end
        end

        S_W_ADDR: begin
          state  <= S_W_MEM;
          ram_we <= 1'b1;
          wr_ack <= 1'b1;
        end

        S_W_MEM: begin
          state      <= S_IDLE;
          count      <= count + CNT_ONE;
          full       <= ((count + CNT_ONE) == DEPTH_CNT);
          empty      <= 1'b0;
          last_grant <= GRANT_WRITE;
        end

        S_R_ADDR: begin
          state  <= S_R_MEM;
          ram_re <= 1'b1;
        end

        S_R_MEM: begin
          state  <= S_R_DONE;
          rd_ack <= 1'b1;
        end

        S_R_DONE: begin
          state      <= S_IDLE;
          count      <= count - CNT_ONE;
          empty      <= (count == CNT_ONE);
          full       <= 1'b0;
          last_grant <= GRANT_READ;
        end

        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

  // Occupancy can only move when the opposite bound is not reached.
  a_no_overflow: assert property (@(posedge clk) disable iff (Clear)
    (state == S_W_MEM) |-> (count != DEPTH_CNT));

  a_no_underflow: assert property (@(posedge clk) disable iff (Clear)
    (state == S_R_DONE) |-> (count != '0));

  a_flags_track_count: assert property (@(posedge clk) disable iff (Clear)
    (full == (count == DEPTH_CNT)) && (empty == (count == '0)));

  a_enable_only_in_addr: assert property (@(posedge clk) disable iff (Clear)
    EnableP |-> ((state == S_W_ADDR) || (state == S_R_ADDR)));

endmodule

// File: tb/tb_fifo_controller.sv
module tb_fifo_controller;

  localparam int         AW     = 4;
  localparam int         DEPTH  = 31;
  localparam logic [3:0] EV_NONE = 4'b0000;
  localparam logic [3:0] EV_WACK = 4'b1000;
  localparam logic [3:0] EV_RACK = 4'b0100;
  localparam logic [3:0] EV_WERR = 4'b0010;
  localparam logic [3:0] EV_RERR = 4'b0001;

  logic        clk = 1'b0;
  logic        Clear = 1'b1;
  logic        wr_req = 1'b0;
  logic        rd_req = 1'b0;
  logic        wr_ack, rd_ack, wr_err, rd_err;
  logic        sel, EnableP, ram_we, ram_re, ptr_clear_n;
  logic [AW:0] count;
  logic        full, empty;

  fifo_controller #(.ADD_WIDTH(AW)) dut (
    .clk         (clk),
    .Clear       (Clear),
    .wr_req      (wr_req),
    .rd_req      (rd_req),
    .wr_ack      (wr_ack),
    .rd_ack      (rd_ack),
    .wr_err      (wr_err),
    .rd_err      (rd_err),
    .sel         (sel),
    .EnableP     (EnableP),
    .ram_we      (ram_we),
    .ram_re      (ram_re),
    .ptr_clear_n (ptr_clear_n),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Scoreboard: one entry per expected response pulse, with the occupancy
  // that must be visible on the cycle after the pulse.
  typedef struct {
    logic [3:0] ev;
    int         cnt;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  logic [3:0] mon_ev;
  bit         pend = 1'b0;
  int         pend_cnt = 0;
  int         en_pulses = 0;
  int         re_pulses = 0;

  always @(negedge clk) begin
    if (Clear) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("sb_count", int'(count), pend_cnt);
        chk("sb_full",  int'(full),  int'(pend_cnt == DEPTH));
        chk("sb_empty", int'(empty), int'(pend_cnt == 0));
        pend = 1'b0;
      end
      if (EnableP) en_pulses++;
      if (ram_re)  re_pulses++;
      mon_ev = {wr_ack, rd_ack, wr_err, rd_err};
      if (mon_ev != EV_NONE) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_event", int'(mon_ev), 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("sb_event", int'(mon_ev), int'(mon_e.ev));
          pend     = 1'b1;
          pend_cnt = mon_e.cnt;
        end
      end
    end
  end

  // Holds the requested sides until each one sees its ack or err, dropping
  // each request right after the edge that ends its response cycle.
  task automatic apply(input bit w, input bit r);
    bit wpend = w;
    bit rpend = r;
    int budget = 40;
    wr_req = w;
    rd_req = r;
    while ((wpend || rpend) && budget > 0) begin
      @(negedge clk);
      if (wpend && (wr_ack || wr_err)) wpend = 1'b0;
      if (rpend && (rd_ack || rd_err)) rpend = 1'b0;
      @(posedge clk); #1;
      wr_req = wpend;
      rd_req = rpend;
      budget--;
    end
    chk("apply_timeout", int'(wpend || rpend), 0);
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  // Asserts Clear immediately, holds it 3 edges, checks reset values,
  // releases it and counts ptr_clear_n low cycles.
  task automatic do_reset();
    int lows = 0;
    Clear  = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count",   int'(count), 0);
    chk("rst_empty",   int'(empty), 1);
    chk("rst_full",    int'(full),  0);
    chk("rst_pclr_n",  int'(ptr_clear_n), 1);
    chk("rst_sel",     int'(sel), 0);
    chk("rst_strobes", int'({EnableP, ram_we, ram_re}), 0);
    chk("rst_pulses",  int'({wr_ack, rd_ack, wr_err, rd_err}), 0);
    Clear = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (!ptr_clear_n) lows++;
    end
    chk("init_pclr_pulse_len", lows, 1);
    chk("init_strobes", int'({EnableP, ram_we, ram_re}), 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit         w;
    bit         r;
    logic [3:0] ev_a;
    int         cnt_a;
    logic [3:0] ev_b;
    int         cnt_b;
  } vec_t;

  vec_t vt[12];

  initial begin
    int re_before;
    int en_before;
    int k;
    int budget;

    // Row 0 is a read on an empty FIFO straight after reset. Rows with both
    // requests exercise the round-robin: after a read the write wins, after
    // a write the read wins, and an empty-side read errors while the write
    // is granted.
    vt[0]  = '{1'b0, 1'b1, EV_RERR, 0, EV_NONE, 0};
    vt[1]  = '{1'b1, 1'b0, EV_WACK, 1, EV_NONE, 0};
    vt[2]  = '{1'b1, 1'b0, EV_WACK, 2, EV_NONE, 0};
    vt[3]  = '{1'b0, 1'b1, EV_RACK, 1, EV_NONE, 0};
    vt[4]  = '{1'b1, 1'b1, EV_WACK, 2, EV_RACK, 1};
    vt[5]  = '{1'b1, 1'b1, EV_WACK, 2, EV_RACK, 1};
    vt[6]  = '{1'b0, 1'b1, EV_RACK, 0, EV_NONE, 0};
    vt[7]  = '{1'b1, 1'b1, EV_RERR, 0, EV_WACK, 1};
    vt[8]  = '{1'b0, 1'b1, EV_RACK, 0, EV_NONE, 0};
    vt[9]  = '{1'b1, 1'b0, EV_WACK, 1, EV_NONE, 0};
    vt[10] = '{1'b1, 1'b1, EV_RACK, 0, EV_WACK, 1};
    vt[11] = '{1'b0, 1'b1, EV_RACK, 0, EV_NONE, 0};

    do_reset();

    // Table-driven transactions
    for (int i = 0; i < 12; i++) begin
      re_before = re_pulses;
      sbq.push_back('{vt[i].ev_a, vt[i].cnt_a});
      if (vt[i].ev_b != EV_NONE) sbq.push_back('{vt[i].ev_b, vt[i].cnt_b});
      apply(vt[i].w, vt[i].r);
      if (i == 0) chk("rd_empty_no_ram_re", re_pulses - re_before, 0);
    end
    chk("table_sb_drained", sbq.size(), 0);

    // Single write: EnableP/sel at T+1, ram_we/wr_ack at T+2
    sbq.push_back('{EV_WACK, 1});
    wr_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("wr_t1_enable", int'(EnableP), 1);
    chk("wr_t1_sel",    int'(sel), 1);
    chk("wr_t1_ack",    int'(wr_ack), 0);
    @(negedge clk);
    chk("wr_t2_ram_we", int'(ram_we), 1);
    chk("wr_t2_ack",    int'(wr_ack), 1);
    chk("wr_t2_enable", int'(EnableP), 0);
    @(posedge clk); #1;
    wr_req = 1'b0;
    @(negedge clk);
    chk("wr_count", int'(count), 1);
    @(posedge clk); #1;

    // Single read: EnableP at T+1 with sel 0, ram_re at T+2, rd_ack at T+3
    sbq.push_back('{EV_RACK, 0});
    rd_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("rd_t1_enable", int'(EnableP), 1);
    chk("rd_t1_sel",    int'(sel), 0);
    @(negedge clk);
    chk("rd_t2_ram_re", int'(ram_re), 1);
    chk("rd_t2_ack",    int'(rd_ack), 0);
    @(negedge clk);
    chk("rd_t3_ack",    int'(rd_ack), 1);
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    chk("rd_count", int'(count), 0);
    chk("rd_empty", int'(empty), 1);
    @(posedge clk); #1;

    // Fill to full, then one rejected write
    for (int i = 0; i < DEPTH; i++) begin
      sbq.push_back('{EV_WACK, i + 1});
      apply(1'b1, 1'b0);
    end
    @(negedge clk);
    chk("fill_full",  int'(full), 1);
    chk("fill_count", int'(count), DEPTH);
    @(posedge clk); #1;
    en_before = en_pulses;
    sbq.push_back('{EV_WERR, DEPTH});
    apply(1'b1, 1'b0);
    @(negedge clk);
    chk("overflow_no_enable", en_pulses - en_before, 0);
    chk("overflow_count", int'(count), DEPTH);
    @(posedge clk); #1;

    // Drain down to 5
    for (int i = DEPTH - 1; i >= 5; i--) begin
      sbq.push_back('{EV_RACK, i});
      apply(1'b0, 1'b1);
    end

    // Contention: both held; expect W,R,W,R with count 6,5,6,5
    sbq.push_back('{EV_WACK, 6});
    sbq.push_back('{EV_RACK, 5});
    sbq.push_back('{EV_WACK, 6});
    sbq.push_back('{EV_RACK, 5});
    wr_req = 1'b1;
    rd_req = 1'b1;
    k = 0;
    budget = 60;
    while (k < 4 && budget > 0) begin
      @(negedge clk);
      if (wr_ack || rd_ack) k++;
      @(posedge clk); #1;
      budget--;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    chk("contention_acks", k, 4);
    @(negedge clk);
    chk("contention_sb_drained", sbq.size(), 0);
    chk("contention_count", int'(count), 5);
    @(posedge clk); #1;

    // Clear during W_ADDR: no ack, count stays 0, INIT pulses the clear again
    do_reset();
    wr_req = 1'b1;
    budget = 10;
    @(negedge clk);
    while (!EnableP && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("clr_mid_reached_waddr", int'(EnableP), 1);
    do_reset();
    repeat (4) @(negedge clk);
    chk("clr_mid_count", int'(count), 0);
    chk("clr_mid_empty", int'(empty), 1);
    chk("clr_mid_sb_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
